// File: rtl/mod12_seq_decoder_if.sv
// Bus between a mod-12 counter value stream and its sequence decoder.
// With MOD12_SEQ_DECODER_STATS_EN defined, the jump/illegal event counters are carried as well.
interface mod12_seq_decoder_if #(
  parameter int W      = 4,
  parameter int WRAP_W = 8
);
  logic [W-1:0]      cnt_in;
  logic              cnt_vld;
  logic              wrap_clr;
  logic              step_up;
  logic              step_dn;
  logic              wrap_up;
  logic              wrap_dn;
  logic              hold;
  logic              jump;
  logic              illegal;
  logic              dir;
  logic              locked;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              wrap_sat;
`ifdef MOD12_SEQ_DECODER_STATS_EN
  logic [7:0]        jump_cnt;
  logic [7:0]        illegal_cnt;
`endif

  modport master (
    output cnt_in, cnt_vld, wrap_clr,
    input  step_up, step_dn, wrap_up, wrap_dn, hold, jump, illegal,
    input  dir, locked, wrap_cnt, wrap_sat
`ifdef MOD12_SEQ_DECODER_STATS_EN
    , input jump_cnt, illegal_cnt
`endif
  );

  modport slave (
    input  cnt_in, cnt_vld, wrap_clr,
    output step_up, step_dn, wrap_up, wrap_dn, hold, jump, illegal,
    output dir, locked, wrap_cnt, wrap_sat
`ifdef MOD12_SEQ_DECODER_STATS_EN
    , output jump_cnt, illegal_cnt
`endif
  );
endinterface

// File: rtl/mod12_seq_decoder.sv
// Classifies each mod-MOD counter transition, tracks direction lock and net wraps.
// Optional jump/illegal event counters are enabled by MOD12_SEQ_DECODER_STATS_EN.
module mod12_seq_decoder #(
  parameter int MOD    = 12,
  parameter int W      = 4,
  parameter int WRAP_W = 8,
  parameter int LOCK_N = 3
) (
  input logic             clk,
  input logic             rst,
  mod12_seq_decoder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

  localparam logic [W-1:0]      TOP  = W'(MOD - 1);
  localparam logic [WRAP_W-1:0] WMAX = {1'b0, {(WRAP_W-1){1'b1}}};
  localparam logic [WRAP_W-1:0] WMIN = {1'b1, {(WRAP_W-1){1'b0}}};

  state_t            state, state_nx;
  logic [W-1:0]      prev, nxt_up, nxt_dn;
  logic [3:0]        run, run_nx;
  logic              dir_r, dir_nx;
  logic              is_ill, is_hold, is_up, is_dn, is_jump, is_wup, is_wdn, fire;
  logic              step_up_r, step_dn_r, wrap_up_r, wrap_dn_r, hold_r, jump_r, illegal_r;
  logic              locked_r, wrap_sat_r;
  logic [WRAP_W-1:0] wrap_cnt_r;

  always_comb begin
    nxt_up  = (prev == TOP) ? '0 : prev + W'(1);
    nxt_dn  = (prev == '0) ? TOP : prev - W'(1);
    is_ill  = bus.cnt_in > TOP;
    is_hold = !is_ill && (bus.cnt_in == prev);
    is_up   = !is_ill && !is_hold && (bus.cnt_in == nxt_up);
    is_dn   = !is_ill && !is_hold && !is_up && (bus.cnt_in == nxt_dn);
    is_jump = !is_ill && !is_hold && !is_up && !is_dn;
    is_wup  = is_up && (prev == TOP);
    is_wdn  = is_dn && (prev == '0);
    fire    = bus.cnt_vld && (state != S_IDLE);

    state_nx = state;
    run_nx   = run;
    dir_nx   = dir_r;
    if (bus.cnt_vld) begin
      if (is_ill) begin
        state_nx = S_IDLE;
        run_nx   = '0;
      end else if (state == S_IDLE) begin
        state_nx = S_ACQ;
        run_nx   = '0;
      end else if (is_up || is_dn) begin
        // Same-direction step extends the run (held at LOCK_N once locked);
        // an opposite step, or the first step after run=0, restarts it at 1.
        if ((run != '0) && (is_up == dir_r)) begin
          run_nx = (state == S_LOCK) ? run : run + 4'd1;
        end else begin
          dir_nx = is_up;
          run_nx = 4'd1;
        end
        state_nx = (run_nx >= 4'(LOCK_N)) ? S_LOCK : S_ACQ;
      end else if (is_jump) begin
        state_nx = S_ACQ;
        run_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      prev       <= '0;
      run        <= '0;
      dir_r      <= 1'b0;
      locked_r   <= 1'b0;
      step_up_r  <= 1'b0;
      step_dn_r  <= 1'b0;
      wrap_up_r  <= 1'b0;
      wrap_dn_r  <= 1'b0;
      hold_r     <= 1'b0;
      jump_r     <= 1'b0;
      illegal_r  <= 1'b0;
      wrap_cnt_r <= '0;
      wrap_sat_r <= 1'b0;
    end else begin
      state     <= state_nx;
      run       <= run_nx;
      dir_r     <= dir_nx;
      locked_r  <= (state_nx == S_LOCK);
      step_up_r <= fire && is_up && !is_wup;
      step_dn_r <= fire && is_dn && !is_wdn;
      wrap_up_r <= fire && is_wup;
      wrap_dn_r <= fire && is_wdn;
      hold_r    <= fire && is_hold;
      jump_r    <= fire && is_jump;
      illegal_r <= bus.cnt_vld && is_ill;
      if (bus.cnt_vld && !is_ill) prev <= bus.cnt_in;

      if (bus.wrap_clr) begin
        wrap_cnt_r <= '0;
        wrap_sat_r <= 1'b0;
      end else if (fire && is_wup) begin
        if (wrap_cnt_r == WMAX) wrap_sat_r <= 1'b1;
        else                    wrap_cnt_r <= wrap_cnt_r + WRAP_W'(1);
      end else if (fire && is_wdn) begin
        if (wrap_cnt_r == WMIN) wrap_sat_r <= 1'b1;
        else                    wrap_cnt_r <= wrap_cnt_r - WRAP_W'(1);
      end
    end
  end

  assign bus.step_up  = step_up_r;
  assign bus.step_dn  = step_dn_r;
  assign bus.wrap_up  = wrap_up_r;
  assign bus.wrap_dn  = wrap_dn_r;
  assign bus.hold     = hold_r;
  assign bus.jump     = jump_r;
  assign bus.illegal  = illegal_r;
  assign bus.dir      = dir_r;
  assign bus.locked   = locked_r;
  assign bus.wrap_cnt = wrap_cnt_r;
  assign bus.wrap_sat = wrap_sat_r;

`ifdef MOD12_SEQ_DECODER_STATS_EN
  logic [7:0] jump_cnt_r, illegal_cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jump_cnt_r    <= '0;
      illegal_cnt_r <= '0;
    end else if (bus.wrap_clr) begin
      jump_cnt_r    <= '0;
      illegal_cnt_r <= '0;
    end else begin
      if (fire && is_jump && (jump_cnt_r != '1))           jump_cnt_r    <= jump_cnt_r + 8'd1;
      if (bus.cnt_vld && is_ill && (illegal_cnt_r != '1)) illegal_cnt_r <= illegal_cnt_r + 8'd1;
    end
  end

  assign bus.jump_cnt    = jump_cnt_r;
  assign bus.illegal_cnt = illegal_cnt_r;
`endif
endmodule

// File: tb/tb_mod12_seq_decoder.sv
// Scoreboard bench for mod12_seq_decoder: directed scenarios plus randomized streams
// checked against an arithmetic reference model (honours MOD12_SEQ_DECODER_STATS_EN).
module tb_mod12_seq_decoder;
  localparam int MOD    = 12;
  localparam int LOCK_N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod12_seq_decoder_if #(.W(4), .WRAP_W(8)) bus ();

  mod12_seq_decoder #(.MOD(MOD), .W(4), .WRAP_W(8), .LOCK_N(LOCK_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // pulses = {step_up, step_dn, wrap_up, wrap_dn, hold, jump, illegal}
  typedef struct {
    logic [6:0] pulses;
    logic       dir;
    logic       locked;
    logic [7:0] wcnt;
    logic       wsat;
    logic [7:0] jc;
    logic [7:0] ic;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  bit m_have;
  int m_prev, m_run, m_wrap, m_jc, m_ic;
  bit m_dir, m_sat;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_prev = 0; m_run = 0; m_wrap = 0; m_jc = 0; m_ic = 0;
    m_dir = 0; m_sat = 0;
  endtask

  function automatic exp_t model_step(input int x, input bit v, input bit clr);
    exp_t e;
    bit su, sd, wu, wd, ho, ju, il;
    int d;
    su = 0; sd = 0; wu = 0; wd = 0; ho = 0; ju = 0; il = 0;
    if (v) begin
      if (x >= MOD) begin
        il = 1; m_have = 0; m_run = 0;
      end else if (!m_have) begin
        m_have = 1; m_prev = x; m_run = 0;
      end else begin
        d = (x - m_prev + MOD) % MOD;
        if (d == 0) ho = 1;
        else if (d == 1 || d == MOD - 1) begin
          if (d == 1) begin if (x == 0) wu = 1; else su = 1; end
          else        begin if (x == MOD - 1) wd = 1; else sd = 1; end
          if (m_run > 0 && m_dir == (d == 1)) m_run++;
          else begin m_dir = (d == 1); m_run = 1; end
        end else begin
          ju = 1; m_run = 0;
        end
        m_prev = x;
      end
    end
    if (clr) begin
      m_wrap = 0; m_sat = 0; m_jc = 0; m_ic = 0;
    end else begin
      if (wu) begin if (m_wrap == 127)  m_sat = 1; else m_wrap++; end
      if (wd) begin if (m_wrap == -128) m_sat = 1; else m_wrap--; end
      if (ju && m_jc < 255) m_jc++;
      if (il && m_ic < 255) m_ic++;
    end
    e.pulses = {su, sd, wu, wd, ho, ju, il};
    e.dir    = m_dir;
    e.locked = m_have && (m_run >= LOCK_N);
    e.wcnt   = 8'(m_wrap);
    e.wsat   = m_sat;
    e.jc     = 8'(m_jc);
    e.ic     = 8'(m_ic);
    return e;
  endfunction

  task automatic drive(input int x, input bit v, input bit clr);
    @(negedge clk);
    bus.cnt_in   = 4'(x);
    bus.cnt_vld  = v;
    bus.wrap_clr = clr;
    q.push_back(model_step(x, v, clr));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 10) begin @(posedge clk); n++; end
    #2;
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic check_reset_state();
    check("rst_pulses", int'({bus.step_up, bus.step_dn, bus.wrap_up, bus.wrap_dn,
                              bus.hold, bus.jump, bus.illegal}), 0);
    check("rst_dir", int'(bus.dir), 0);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_wrap_cnt", int'(bus.wrap_cnt), 0);
    check("rst_wrap_sat", int'(bus.wrap_sat), 0);
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    bus.cnt_vld  = 1'b0;
    bus.wrap_clr = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a registered result for the sample issued before it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        check("pulses", int'({bus.step_up, bus.step_dn, bus.wrap_up, bus.wrap_dn,
                              bus.hold, bus.jump, bus.illegal}), int'(e.pulses));
        check("dir", int'(bus.dir), int'(e.dir));
        check("locked", int'(bus.locked), int'(e.locked));
        check("wrap_cnt", int'(bus.wrap_cnt), int'(e.wcnt));
        check("wrap_sat", int'(bus.wrap_sat), int'(e.wsat));
`ifdef MOD12_SEQ_DECODER_STATS_EN
        check("jump_cnt", int'(bus.jump_cnt), int'(e.jc));
        check("illegal_cnt", int'(bus.illegal_cnt), int'(e.ic));
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_a[] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0, 1};
    int seq_b[] = '{2, 1, 0, 11, 10, 9};
    int seq_c[] = '{5, 9, 10, 11, 0, 13, 4, 4, 5};
    int x, r;
    bus.cnt_in   = '0;
    bus.cnt_vld  = 1'b0;
    bus.wrap_clr = 1'b0;
    model_reset();
    #12;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;

    // Lock up, wrap up, reverse through a wrap down, jump and re-lock, illegal recovery.
    foreach (seq_a[i]) drive(seq_a[i], 1'b1, 1'b0);
    foreach (seq_b[i]) drive(seq_b[i], 1'b1, 1'b0);
    drive(6, 1'b0, 1'b0);
    foreach (seq_c[i]) drive(seq_c[i], 1'b1, 1'b0);

    // Saturate at +127, then clear together with a wrap event.
    drive(0, 1'b1, 1'b1);
    for (int w = 0; w < 129; w++)
      for (int k = 1; k <= MOD; k++) drive(k % MOD, 1'b1, 1'b0);
    for (int k = 1; k < MOD; k++) drive(k, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b1);

    // Saturate at -128 going down.
    for (int w = 0; w < 130; w++)
      for (int k = MOD - 1; k >= 0; k--) drive(k, 1'b1, 1'b0);

    // Randomized stream biased toward runs of steps.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      x = (m_prev + 1) % MOD;
      else if (r < 72) x = (m_prev + MOD - 1) % MOD;
      else if (r < 82) x = m_prev;
      else if (r < 94) x = (m_prev + $urandom_range(2, MOD - 2)) % MOD;
      else             x = $urandom_range(MOD, 15);
      drive(x, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 3);
    end

    // Reset mid-stream: next sample is a fresh reference.
    do_reset();
    foreach (seq_b[i]) drive(seq_b[i], 1'b1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
